// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit.
//   Reads the current PC, issues one word read per instruction on the memory
//   request channel, captures the response and presents it to decode over a
//   valid/ready handshake. It is the only writer of the PC register. A
//   consumed instruction advances the PC by 4, and a redirect loads the
//   redirect target.
//
// Ports:
//   clock, reset                  single clock, synchronous active-high reset
//   pc_rdata                      current PC value
//   pc_wen, pc_wdata              PC write port (combinational, one cycle per event)
//   redirect_valid, redirect_pc   branch/trap redirect request
//   mem_req_valid/ready/addr      fetch request channel
//   mem_rsp_valid/data/err        fetch response channel
//   inst_valid/ready              decode handshake
//   inst_data, inst_pc, inst_fault  fetched instruction, its PC, fault flag
module ifu_fetch #(
    parameter int unsigned REG_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [REG_W-1:0] pc_rdata,
    output logic             pc_wen,
    output logic [REG_W-1:0] pc_wdata,
    input  logic             redirect_valid,
    input  logic [REG_W-1:0] redirect_pc,
    output logic             mem_req_valid,
    input  logic             mem_req_ready,
    output logic [REG_W-1:0] mem_req_addr,
    input  logic             mem_rsp_valid,
    input  logic [REG_W-1:0] mem_rsp_data,
    input  logic             mem_rsp_err,
    output logic             inst_valid,
    input  logic             inst_ready,
    output logic [REG_W-1:0] inst_data,
    output logic [REG_W-1:0] inst_pc,
    output logic             inst_fault
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StHold} state_e;

    state_e           state_q, state_d;
    logic             stale_q, stale_d;
    logic [REG_W-1:0] inst_data_q, inst_data_d;
    logic [REG_W-1:0] inst_pc_q, inst_pc_d;
    logic             inst_fault_q, inst_fault_d;
    logic             aligned;

    assign aligned      = (pc_rdata[1:0] == 2'b00);
    assign mem_req_addr = pc_rdata;
    assign inst_data    = inst_data_q;
    assign inst_pc      = inst_pc_q;
    assign inst_fault   = inst_fault_q;

    always_comb begin
        state_d       = state_q;
        stale_d       = stale_q;
        inst_data_d   = inst_data_q;
        inst_pc_d     = inst_pc_q;
        inst_fault_d  = inst_fault_q;
        pc_wen        = 1'b0;
        pc_wdata      = inst_pc_q + REG_W'(4);
        mem_req_valid = 1'b0;
        inst_valid    = 1'b0;

        unique case (state_q)
            StIdle: begin
                state_d = StReq;
            end
            StReq: begin
                mem_req_valid = !redirect_valid && aligned;
                if (!redirect_valid) begin
                    if (!aligned) begin
                        // Misaligned PC never reaches the bus; hand decode a fault.
                        inst_fault_d = 1'b1;
                        inst_data_d  = '0;
                        inst_pc_d    = pc_rdata;
                        state_d      = StHold;
                    end else if (mem_req_ready) begin
                        inst_pc_d = pc_rdata;
                        state_d   = StWait;
                    end
                end
            end
            StWait: begin
                if (redirect_valid) begin
                    if (mem_rsp_valid) begin
                        // Response lands with the redirect: drop it right away.
                        stale_d = 1'b0;
                        state_d = StReq;
                    end else begin
                        stale_d = 1'b1;
                    end
                end else if (mem_rsp_valid) begin
                    stale_d = 1'b0;
                    if (stale_q) begin
                        state_d = StReq;
                    end else begin
                        inst_data_d  = mem_rsp_err ? '0 : mem_rsp_data;
                        inst_fault_d = mem_rsp_err;
                        state_d      = StHold;
                    end
                end
            end
            StHold: begin
                inst_valid = 1'b1;
                if (inst_ready) begin
                    pc_wen  = 1'b1;
                    state_d = StReq;
                end
                if (redirect_valid) begin
                    state_d = StReq;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Redirect wins over the sequential advance, including a coincident handshake.
        if (redirect_valid && (state_q != StIdle)) begin
            pc_wen   = 1'b1;
            pc_wdata = redirect_pc;
        end

        // Reset aborts at once, before the state register has been cleared.
        if (reset) begin
            pc_wen        = 1'b0;
            mem_req_valid = 1'b0;
            inst_valid    = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            stale_q      <= 1'b0;
            inst_data_q  <= '0;
            inst_pc_q    <= '0;
            inst_fault_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            stale_q      <= stale_d;
            inst_data_q  <= inst_data_d;
            inst_pc_q    <= inst_pc_d;
            inst_fault_q <= inst_fault_d;
        end
    end

endmodule
